// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client memory arbiter: FSM encoding and
// default memory-interface widths.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 32;

    // Client 0 wins the first tie after reset because client 1 is deemed last served.
    localparam logic LAST_GRANT_RESET = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client block-memory arbiter (instruction cache = client 0, data cache = client 1)
// with alternating priority on ties and busywait-handshake completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              c0_read,
    input  logic              c0_write,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic [DATA_W-1:0] c0_writedata,
    output logic [DATA_W-1:0] c0_readdata,
    output logic              c0_busywait,

    input  logic              c1_read,
    input  logic              c1_write,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic [DATA_W-1:0] c1_writedata,
    output logic [DATA_W-1:0] c1_readdata,
    output logic              c1_busywait,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    arb_state_t state;
    logic       last_grant;
    logic       seen_busy;

    logic req0;
    logic req1;
    logic done0;
    logic done1;

    assign req0 = c0_read | c0_write;
    assign req1 = c1_read | c1_write;

    // A grant only completes once memory has been observed busy and then released.
    assign done0 = (state == GRANT0) && seen_busy && !mem_busywait;
    assign done1 = (state == GRANT1) && seen_busy && !mem_busywait;

    assign c0_busywait = req0 && !done0;
    assign c1_busywait = req1 && !done1;

    // NOTE: state is updated only with non-blocking assignments so every register
    // in this block sees the pre-edge values of its peers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= LAST_GRANT_RESET;
            seen_busy   <= 1'b0;
            c0_readdata <= '0;
            c1_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    seen_busy <= 1'b0;
                    if (req0 && req1) begin
                        state <= last_grant ? GRANT0 : GRANT1;
                    end else if (req0) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (!req0) begin
                        state <= IDLE;
                    end else if (done0) begin
                        state       <= IDLE;
                        last_grant  <= 1'b0;
                        c0_readdata <= mem_readdata;
                    end else if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (!req1) begin
                        state <= IDLE;
                    end else if (done1) begin
                        state       <= IDLE;
                        last_grant  <= 1'b1;
                        c1_readdata <= mem_readdata;
                    end else if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state)
            GRANT0: begin
                mem_write     = c0_write;
                mem_read      = c0_read && !c0_write;
                mem_address   = c0_address;
                mem_writedata = c0_writedata;
            end
            GRANT1: begin
                mem_write     = c1_write;
                mem_read      = c1_read && !c1_write;
                mem_address   = c1_address;
                mem_writedata = c1_writedata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: client requests push expected memory
// transactions, a behavioural memory pops and checks them as they are granted.
module tb_mem_arbiter;

    typedef struct {
        int          client;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clock;
    logic        reset;
    logic        c0_read, c0_write, c1_read, c1_write;
    logic [5:0]  c0_address, c1_address;
    logic [31:0] c0_writedata, c1_writedata;
    logic [31:0] c0_readdata, c1_readdata;
    logic        c0_busywait, c1_busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    txn_t        sb[$];
    logic [31:0] exp_rd[2];
    int          n_checks = 0;
    int          n_pass   = 0;

    mem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .c0_read      (c0_read),
        .c0_write     (c0_write),
        .c0_address   (c0_address),
        .c0_writedata (c0_writedata),
        .c0_readdata  (c0_readdata),
        .c0_busywait  (c0_busywait),
        .c1_read      (c1_read),
        .c1_write     (c1_write),
        .c1_address   (c1_address),
        .c1_writedata (c1_writedata),
        .c1_readdata  (c1_readdata),
        .c1_busywait  (c1_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    endtask

    function automatic logic client_req(input int c);
        return (c == 0) ? (c0_read | c0_write) : (c1_read | c1_write);
    endfunction

    function automatic logic client_busy(input int c);
        return (c == 0) ? c0_busywait : c1_busywait;
    endfunction

    function automatic logic [31:0] client_rd(input int c);
        return (c == 0) ? c0_readdata : c1_readdata;
    endfunction

    task automatic issue(input int c, input logic wr, input logic both_rw,
                         input logic [5:0] addr, input logic [31:0] data);
        txn_t t;
        if (c == 0) begin
            c0_read = !wr || both_rw; c0_write = wr || both_rw;
            c0_address = addr; c0_writedata = data;
        end else begin
            c1_read = !wr || both_rw; c1_write = wr || both_rw;
            c1_address = addr; c1_writedata = data;
        end
        t.client = c; t.wr = wr || both_rw; t.addr = addr; t.wdata = data;
        sb.push_back(t);
    endtask

    task automatic drop(input int c);
        if (c == 0) begin c0_read = 1'b0; c0_write = 1'b0; end
        else        begin c1_read = 1'b0; c1_write = 1'b0; end
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    // Waits for a memory strobe, then pops and checks the expected transaction.
    task automatic wait_grant(output txn_t t, output bit ok);
        int n = 0;
        ok = 1'b0;
        t.client = 0; t.wr = 1'b0; t.addr = '0; t.wdata = '0;
        @(negedge clock);
        while (!(mem_read || mem_write) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        t = sb.pop_front();
        if (n >= 20) begin
            check("strobe_timeout", 32'd0, 32'd1);
            return;
        end
        ok = 1'b1;
        check("grant_addr",  mem_address, t.addr);
        check("mem_write",   mem_write, t.wr);
        check("mem_read",    mem_read, !t.wr);
        check("mem_wdata",   mem_writedata, t.wdata);
        check("busy_grant",  client_busy(t.client), 1'b1);
        check("busy_other",  client_busy(1 - t.client), client_req(1 - t.client));
    endtask

    // Behavioural memory: optional quiet cycles, lat busy cycles, then release.
    task automatic serve(input int gap, input int lat, input logic [31:0] rdata);
        txn_t t;
        bit   ok;
        wait_grant(t, ok);
        if (!ok) return;
        mem_busywait = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clock); @(negedge clock);
            check("no_early_done_strobe", mem_read | mem_write, 1'b1);
            check("no_early_done_busy", client_busy(t.client), 1'b1);
        end
        mem_busywait = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(posedge clock); @(negedge clock);
            check("busy_hold", client_busy(t.client), 1'b1);
            check("busy_other_hold", client_busy(1 - t.client), client_req(1 - t.client));
            check("addr_hold", mem_address, t.addr);
        end
        mem_busywait = 1'b0;
        mem_readdata = rdata;
        #1;
        check("done_busywait_low", client_busy(t.client), 1'b0);
        @(posedge clock); #1;
        exp_rd[t.client] = rdata;
        check("readdata", client_rd(t.client), exp_rd[t.client]);
        check("readdata_other", client_rd(1 - t.client), exp_rd[1 - t.client]);
        drop(t.client);
        @(negedge clock);
        check("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    endtask

    initial begin
        txn_t t;
        bit   ok;
        reset = 1'b1;
        c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
        c0_address = '0; c1_address = '0; c0_writedata = '0; c1_writedata = '0;
        mem_readdata = '0; mem_busywait = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_rd0", c0_readdata, 32'd0);
        check("rst_rd1", c1_readdata, 32'd0);
        check("rst_busy", {30'd0, c0_busywait, c1_busywait}, 32'd0);

        // Single client read with a 5-cycle busy memory.
        @(posedge clock); #1 issue(1, 1'b0, 1'b0, 6'h05, 32'h0);
        serve(0, 5, 32'hDEADBEEF);

        // Single client write; client 0 stays idle and must never stall.
        @(posedge clock); #1 issue(1, 1'b1, 1'b0, 6'h3F, 32'h12345678);
        serve(0, 3, 32'hA5A5A5A5);

        // Simultaneous requests right after reset: client 0 first.
        do_reset();
        issue(0, 1'b0, 1'b0, 6'h01, 32'h0);
        issue(1, 1'b1, 1'b0, 6'h02, 32'hCAFEF00D);
        serve(0, 2, 32'h11111111);
        serve(0, 2, 32'h22222222);

        // Both continuously requesting: grants alternate 0,1,0,1.
        @(posedge clock); #1;
        issue(0, 1'b0, 1'b0, 6'h10, 32'h0);
        issue(1, 1'b0, 1'b0, 6'h20, 32'h0);
        serve(0, 1, 32'h00000A01);
        issue(0, 1'b0, 1'b1, 6'h11, 32'h55AA55AA);
        serve(0, 2, 32'h00000B01);
        issue(1, 1'b0, 1'b0, 6'h21, 32'h0);
        serve(0, 1, 32'h00000A02);
        serve(0, 3, 32'h00000B02);

        // Memory quiet for the first grant cycles: no completion until busy seen.
        @(posedge clock); #1 issue(0, 1'b0, 1'b0, 6'h0C, 32'h0);
        serve(2, 2, 32'h0C0C0C0C);

        // Abort: client 1 drops mid-grant; no capture, last_grant stays 0.
        @(posedge clock); #1 issue(1, 1'b0, 1'b0, 6'h22, 32'h0);
        wait_grant(t, ok);
        mem_busywait = 1'b1;
        @(posedge clock); #1;
        drop(1);
        mem_busywait = 1'b0;
        mem_readdata = 32'hBAD0BAD0;
        @(posedge clock); #1;
        check("abort_rd1", c1_readdata, exp_rd[1]);
        check("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        issue(1, 1'b0, 1'b0, 6'h23, 32'h0);
        issue(0, 1'b0, 1'b0, 6'h13, 32'h0);
        serve(0, 1, 32'h0000C001);
        serve(0, 1, 32'h0000C000);

        // Reset while client 0 is granted and memory busy.
        @(posedge clock); #1 issue(0, 1'b0, 1'b0, 6'h33, 32'h0);
        wait_grant(t, ok);
        mem_busywait = 1'b1;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mid_rd0", c0_readdata, 32'd0);
        check("rst_mid_busy0", c0_busywait, 1'b1);
        drop(0);
        mem_busywait = 1'b0;
        @(negedge clock);
        check("final_scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, memory block-address width.
REQ-002 Parameter DATA_W, default 32, memory block-data width.
REQ-003 clock  input  1  single system clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 c0_read, c0_write  input  1 each  client 0 (instruction cache) block read/write request.
REQ-006 c0_address  input  ADDR_W  client 0 block address.
REQ-007 c0_writedata  input  DATA_W  client 0 write block.
REQ-008 c0_readdata  output  DATA_W  client 0 read block.
REQ-009 c0_busywait  output  1  client 0 stall.
REQ-010 c1_read, c1_write, c1_address, c1_writedata, c1_readdata, c1_busywait  same widths and directions  client 1 (data cache) port.
REQ-011 mem_read, mem_write  output  1 each  memory request strobes.
REQ-012 mem_address  output  ADDR_W; mem_writedata  output  DATA_W.
REQ-013 mem_readdata  input  DATA_W; mem_busywait  input  1  memory stall.

Function
REQ-014 Request req_n = cn_read | cn_write; clients hold request, address and data stable while cn_busywait is high.
REQ-015 States: IDLE, GRANT0, GRANT1; register last_grant (1 bit); register seen_busy (1 bit).
REQ-016 IDLE: if exactly one req_n, next state GRANTn; if both, grant the client != last_grant; else stay IDLE.
REQ-017 In IDLE all mem_read, mem_write are 0; mem_address, mem_writedata are 0.
REQ-018 In GRANTn, mem_* outputs are driven combinationally from client n's request signals; the other client's inputs are ignored.
REQ-019 cn_read && cn_write together: treated as write (mem_write=1, mem_read=0).
REQ-020 seen_busy clears on entry to GRANTn and sets on any posedge in GRANTn with mem_busywait=1.
REQ-021 Completion: posedge in GRANTn with seen_busy=1 and mem_busywait=0; on that edge state -> IDLE, last_grant <= n, cn_readdata register <= mem_readdata.
REQ-022 cn_busywait = req_n && !(state==GRANTn && seen_busy && !mem_busywait); a requesting client sees busywait high from the cycle it raises req until the completion cycle.
REQ-023 A client dropping its request while granted (abort): state -> IDLE on the next posedge, last_grant unchanged, readdata register not updated.
REQ-024 Minimum latency request-to-completion: 1 cycle IDLE arbitration + memory latency; back-to-back requests from both clients strictly alternate.
REQ-025 cn_readdata holds its last captured value between transactions.

Reset
REQ-026 On posedge with reset=1: state=IDLE, last_grant=1 (client 0 wins first tie), seen_busy=0, c0_readdata=c1_readdata=0.
REQ-027 Reset mid-transaction abandons it; mem_read/mem_write are 0 from the cycle after the reset edge; client busywait follows REQ-022.

Structure
REQ-028 State encoding (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10) and default widths reside in a shared package/include with the memory-interface constants.
REQ-029 Single flat module; no sub-module required.

Verification
REQ-030 Reset, then c1_read addr 6'h05, memory busy 5 cycles, mem_readdata 32'hDEADBEEF -> mem_address=6'h05, c1_readdata=32'hDEADBEEF, c1_busywait low in completion cycle.
REQ-031 c0_read and c1_write raised same cycle after reset -> client 0 granted first, client 1 second; no overlap of mem strobes.
REQ-032 Both clients requesting continuously for 4 transactions -> grants 0,1,0,1.
REQ-033 c1_write addr 6'h3F data 32'h12345678 while c0 idle -> mem_write=1, mem_writedata=32'h12345678, mem_read=0, c0_busywait=0 throughout.
REQ-034 reset asserted during GRANT0 with mem_busywait=1 -> state IDLE, mem strobes 0 next cycle, c0_readdata=0.
REQ-035 Memory holds mem_busywait=0 for first GRANT cycle -> no completion until busywait seen high then low.
